// File: rtl/oled_spi_arbiter.sv
// Two-port arbiter in front of a single SPI byte sender for an OLED panel.
// Grants one requester per burst, drives D/C per burst and aborts on a stalled sender.
module oled_spi_arbiter #(
  parameter int ARB_MODE    = 0,
  parameter int TIMEOUT_CYC = 1024,
  parameter int TO_W        = 11
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ0,
  input  logic       REQ1,
  input  logic [7:0] DATA0,
  input  logic [7:0] DATA1,
  input  logic       DC0,
  input  logic       DC1,
  input  logic       LAST0,
  input  logic       LAST1,
  output logic       ACK0,
  output logic       ACK1,
  output logic [1:0] GNT,
  output logic       BUSY,
  output logic       ERR,
  output logic       ERR_SRC,
  output logic       SPI_EN,
  output logic [7:0] SPI_DATA,
  input  logic       SPI_FIN,
  output logic       DC
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, RELEASE} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_t          state_q, state_d;
  logic [1:0]      req, dc_in, last_in;
  logic [1:0][7:0] data_in;
  logic [1:0]      gnt_q, gnt_d, ack_q, ack_d;
  logic            sel_q, sel_d, last_q, last_d, rr_q, rr_d, pick;
  logic [TO_W-1:0] tcnt_q, tcnt_d;
  logic            busy_q, busy_d, err_q, err_d, src_q, src_d;
  logic            en_q, en_d, dc_q, dc_d;
  logic [7:0]      data_q, data_d;
  logic            to_hit, finish, abort;

  assign req     = {REQ1, REQ0};
  assign data_in = {DATA1, DATA0};
  assign dc_in   = {DC1, DC0};
  assign last_in = {LAST1, LAST0};

  // rr_q holds the last granted port; on a tie round-robin hands the grant to the other one
  always_comb begin
    if (ARB_MODE != 0 && req == 2'b11) pick = ~rr_q;
    else                               pick = ~req[0];
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    rr_d    = rr_q;
    tcnt_d  = tcnt_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    ack_d   = 2'b00;
    err_d   = 1'b0;
    src_d   = src_q;
    en_d    = en_q;
    data_d  = data_q;
    dc_d    = dc_q;
    to_hit  = (tcnt_q == TO_LAST);
    finish  = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          sel_d   = pick;
          gnt_d   = pick ? 2'b10 : 2'b01;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // D/C only moves here, while the sender is still deselected
        data_d  = data_in[sel_q];
        dc_d    = dc_in[sel_q];
        last_d  = last_in[sel_q];
        en_d    = 1'b1;
        tcnt_d  = '0;
        state_d = SEND;
      end
      SEND: begin
        if (SPI_FIN) begin
          en_d        = 1'b0;
          ack_d[sel_q] = 1'b1;
          tcnt_d      = '0;
          state_d     = RELEASE;
        end else if (to_hit) begin
          abort = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      RELEASE: begin
        if (!SPI_FIN) begin
          if (last_q || !req[sel_q]) finish  = 1'b1;
          else                       state_d = LOAD;
        end else if (to_hit) begin
          abort = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (finish || abort) begin
      state_d = IDLE;
      gnt_d   = 2'b00;
      busy_d  = 1'b0;
      en_d    = 1'b0;
      rr_d    = sel_q;
    end
    if (abort) begin
      err_d = 1'b1;
      src_d = sel_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b0;
      rr_q    <= 1'b1;
      tcnt_q  <= '0;
      gnt_q   <= 2'b00;
      busy_q  <= 1'b0;
      ack_q   <= 2'b00;
      err_q   <= 1'b0;
      src_q   <= 1'b0;
      en_q    <= 1'b0;
      data_q  <= 8'h00;
      dc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      rr_q    <= rr_d;
      tcnt_q  <= tcnt_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      src_q   <= src_d;
      en_q    <= en_d;
      data_q  <= data_d;
      dc_q    <= dc_d;
    end
  end

  assign ACK0     = ack_q[0];
  assign ACK1     = ack_q[1];
  assign GNT      = gnt_q;
  assign BUSY     = busy_q;
  assign ERR      = err_q;
  assign ERR_SRC  = src_q;
  assign SPI_EN   = en_q;
  assign SPI_DATA = data_q;
  assign DC       = dc_q;

endmodule
